// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared constants, FSM encoding and index-width helper for the streaming argmax
package argmax_pkg;

    localparam int CHUNK_SIZE  = 16;
    localparam int CHUNK_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Global index = chunk number above the 4-bit in-chunk position.
    function automatic int idx_w(input int num_chunks);
        return CHUNK_IDX_W + $clog2(num_chunks);
    endfunction

endpackage

// File: rtl/parallel_argmax_signed_16_inputs.sv
// rtl/parallel_argmax_signed_16_inputs.sv - combinational signed max/argmax over 16 elements
module parallel_argmax_signed_16_inputs
    import argmax_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic signed [WIDTH-1:0]       data [CHUNK_SIZE],
    output logic signed [WIDTH-1:0]       max_val,
    output logic        [CHUNK_IDX_W-1:0] max_idx
);

    // >= lets a later equal element take over, so ties resolve to the highest index.
    always_comb begin
        max_val = data[0];
        max_idx = '0;
        for (int k = 1; k < CHUNK_SIZE; k++) begin
            if (data[k] >= max_val) begin
                max_val = data[k];
                max_idx = CHUNK_IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/streaming_argmax_controller.sv
// rtl/streaming_argmax_controller.sv - chunked running argmax over NUM_CHUNKS*16 elements; optional ARGMAX_PIPE_EN
module streaming_argmax_controller
    import argmax_pkg::*;
#(
    parameter  int WIDTH      = 5,
    parameter  int NUM_CHUNKS = 4,
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int IDX_W      = idx_w(NUM_CHUNKS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHUNK_SIZE*WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WIDTH-1:0]       out_max,
    output logic        [IDX_W-1:0]       out_argmax
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [WIDTH-1:0]  run_max;
    logic [IDX_W-1:0]         run_idx;

    logic signed [WIDTH-1:0]  elems [CHUNK_SIZE];
    logic signed [WIDTH-1:0]  c_max;
    logic [CHUNK_IDX_W-1:0]   c_arg;

    for (genvar k = 0; k < CHUNK_SIZE; k++) begin : g_unpack
        assign elems[k] = in_data[k*WIDTH +: WIDTH];
    end

    parallel_argmax_signed_16_inputs #(
        .WIDTH   (WIDTH)
    ) u_argmax (
        .data    (elems),
        .max_val (c_max),
        .max_idx (c_arg)
    );

    logic accept;
    assign in_ready = (state == ST_ACCUM) && !rst;
    assign accept   = in_valid && in_ready;

    // a_* is the chunk result entering the accumulator (registered first when pipelined).
    logic                     a_valid;
    logic signed [WIDTH-1:0]  a_max;
    logic [CHUNK_IDX_W-1:0]   a_arg;
    logic [CNT_W-1:0]         a_chunk;

`ifdef ARGMAX_PIPE_EN
    logic                     p_valid;
    logic signed [WIDTH-1:0]  p_max;
    logic [CHUNK_IDX_W-1:0]   p_arg;
    logic [CNT_W-1:0]         p_chunk;

    assign a_valid = p_valid;
    assign a_max   = p_max;
    assign a_arg   = p_arg;
    assign a_chunk = p_chunk;
`else
    assign a_valid = accept;
    assign a_max   = c_max;
    assign a_arg   = c_arg;
    assign a_chunk = cnt;
`endif

    logic                     take;
    logic                     a_last;
    logic signed [WIDTH-1:0]  new_max;
    logic [IDX_W-1:0]         new_idx;

    // The first chunk seeds the running max; later equal maxima win so the global tie goes high.
    always_comb begin
        take    = (a_chunk == '0) || (a_max >= run_max);
        a_last  = (a_chunk == LAST);
        new_max = take ? a_max : run_max;
        new_idx = take ? IDX_W'({a_chunk, a_arg}) : run_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCUM;
            cnt        <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            out_valid  <= 1'b0;
            out_max    <= '0;
            out_argmax <= '0;
`ifdef ARGMAX_PIPE_EN
            p_valid    <= 1'b0;
`endif
        end else begin
`ifdef ARGMAX_PIPE_EN
            p_valid <= accept;
            if (accept) begin
                p_max   <= c_max;
                p_arg   <= c_arg;
                p_chunk <= cnt;
            end
`endif
            if (accept) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end

            if (a_valid) begin
                run_max <= new_max;
                run_idx <= new_idx;
                if (a_last) begin
                    out_max    <= new_max;
                    out_argmax <= new_idx;
                end
            end

            case (state)
                ST_ACCUM: begin
                    if (accept && cnt == LAST) begin
`ifdef ARGMAX_PIPE_EN
                        state     <= ST_DRAIN;
`else
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_ACCUM;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_streaming_argmax_controller.sv
// tb/tb_streaming_argmax_controller.sv - directed bench with a whole-vector argmax model and per-cycle result checker
module tb_streaming_argmax_controller;

    localparam int WIDTH      = 5;
    localparam int NUM_CHUNKS = 4;
    localparam int NELEM      = NUM_CHUNKS * 16;
    localparam int IDX_W      = 6;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [16*WIDTH-1:0]       in_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b1;
    logic signed [WIDTH-1:0]   out_max;
    logic [IDX_W-1:0]          out_argmax;

    int n_checks = 0;
    int n_fail   = 0;
    int vec [NELEM];
    int exp_max_q [$];
    int exp_idx_q [$];

    always #5 clk = ~clk;

    streaming_argmax_controller #(
        .WIDTH      (WIDTH),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_argmax (out_argmax)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Whole-vector reference: largest value, highest index among equals.
    task automatic model(output int m, output int ix);
        m  = vec[0];
        ix = 0;
        for (int i = 1; i < NELEM; i++) begin
            if (vec[i] >= m) begin
                m  = vec[i];
                ix = i;
            end
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < NELEM; i++) vec[i] = v;
    endtask

    task automatic pin_model(input string name, input int em, input int ei);
        int m, ix;
        model(m, ix);
        check({name, "_model_max"}, m, em);
        check({name, "_model_idx"}, ix, ei);
    endtask

    task automatic send_beat(input int c);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 16; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(vec[c*16 + k]);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("beat_accept", int'(got), 1);
    endtask

    task automatic send_vector(input bit gaps);
        int m, ix;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            send_beat(c);
            if (gaps && c < NUM_CHUNKS - 1) begin
                @(posedge clk);
                #1;
            end
        end
        model(m, ix);
        exp_max_q.push_back(m);
        exp_idx_q.push_back(ix);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 20 && exp_max_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("result_drained", exp_max_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("in_ready_while_done", int'(in_ready), 0);
            if (exp_max_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("out_max", int'(out_max), exp_max_q[0]);
                check("out_argmax", int'(out_argmax), exp_idx_q[0]);
                if (out_ready) begin
                    void'(exp_max_q.pop_front());
                    void'(exp_idx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_max", int'(out_max), 0);
        check("reset_out_argmax", int'(out_argmax), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single peak with latency check
        fill(-16);
        vec[3] = 7;
        pin_model("single", 7, 3);
        send_vector(1'b0);
        @(negedge clk);
`ifdef ARGMAX_PIPE_EN
        check("latency_drain_cycle", int'(out_valid), 0);
        check("drain_in_ready", int'(in_ready), 0);
        @(negedge clk);
`endif
        check("latency_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        wait_drain();

        // All-equal vector: highest global index wins
        fill(0);
        pin_model("global_tie", 0, 63);
        send_vector(1'b0);
        wait_drain();

        // Cross-chunk tie goes to the later chunk
        fill(-1);
        vec[21] = 15;
        vec[50] = 15;
        pin_model("cross_tie", 15, 50);
        send_vector(1'b0);
        wait_drain();

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        fill(-16);
        vec[3] = 7;
        send_vector(1'b0);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("bp_out_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid_hold", int'(out_valid), 1);
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_out_max_hold", int'(out_max), 7);
            check("bp_out_argmax_hold", int'(out_argmax), 3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        fill(-8);
        vec[32] = 4;
        pin_model("after_bp", 4, 32);
        send_vector(1'b0);
        wait_drain();

        // Mid-vector reset discards the partial vector
        fill(15);
        send_beat(0);
        send_beat(1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready_back", int'(in_ready), 1);
        @(posedge clk);
        #1;
        fill(-5);
        vec[17] = 3;
        pin_model("after_rst", 3, 17);
        send_vector(1'b0);
        wait_drain();

        // Bubbles between beats
        fill(-1);
        vec[21] = 15;
        vec[50] = 15;
        send_vector(1'b1);
        wait_drain();

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
